// File: rtl/fp16_pkg.sv
// FP16 encoding constants and the drain FSM state type shared by the converter and drain block.
// No logic here; pure definitions.
package fp16_pkg;

   localparam int FP16_EXP_BIAS = 15;
   localparam int FP16_EXP_MAX  = 31;
   localparam int FP16_MANT_W   = 10;
   localparam logic [15:0] FP16_INF = 16'h7C00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2
   } drain_state_e;

endpackage

// File: rtl/fx_to_fp16.sv
// Block fixed-point (signed acc scaled by 2^(exp-15-FRAC_BITS)) to FP16, purely combinational.
// Truncates toward zero, saturates to +/-Inf, flushes would-be subnormals to signed zero.
module fx_to_fp16
   import fp16_pkg::*;
#(
   parameter int ACC_WIDTH = 32,
   parameter int FRAC_BITS = 10
) (
   input  logic [ACC_WIDTH-1:0] acc,
   input  logic [4:0]           exp,
   output logic [15:0]          fp16
);

   localparam int PW = $clog2(ACC_WIDTH);
   localparam logic [PW-1:0] TOP = PW'(ACC_WIDTH - 1);
   localparam logic signed [15:0] E_MAX = 16'(FP16_EXP_MAX);

   logic                   sign;
   logic [ACC_WIDTH-1:0]   mag;
   logic [ACC_WIDTH-1:0]   norm;
   logic [PW-1:0]          lead;
   logic signed [15:0]     e_wide;
   logic [FP16_MANT_W-1:0] mant;

   // Negation in unsigned ACC_WIDTH bits keeps the most negative input correct.
   assign sign = acc[ACC_WIDTH-1];
   assign mag  = sign ? (~acc + ACC_WIDTH'(1)) : acc;

   always_comb begin
      lead = '0;
      for (int b = 0; b < ACC_WIDTH; b++) begin
         if (mag[b]) lead = b[PW-1:0];
      end
   end

   assign norm   = mag << (TOP - lead);
   assign mant   = FP16_MANT_W'(norm >> (ACC_WIDTH - 1 - FP16_MANT_W));
   assign e_wide = 16'(exp) + 16'(lead) - 16'(FRAC_BITS);

   always_comb begin
      if (mag == '0)
         fp16 = 16'h0000;
      else if (e_wide >= E_MAX)
         fp16 = {sign, FP16_INF[14:0]};
      else if (e_wide <= 16'sd0)
         fp16 = {sign, 15'h0000};
      else
         fp16 = {sign, e_wide[4:0], mant};
   end

endmodule

// File: rtl/systolic_drain.sv
// Snapshots an N*N tile on the rising edge of acc_done and streams FP16 results in PE order.
// First valid 2 cycles after capture, then one per cycle; output register holds under out_ready=0.
module systolic_drain
   import fp16_pkg::*;
#(
   parameter int ACC_WIDTH = 32,
   parameter int N         = 2,
   parameter int FRAC_BITS = 10,
   localparam int NE       = N * N,
   localparam int IDX_W    = (NE > 1) ? $clog2(NE) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    acc_done,
   input  logic [NE*ACC_WIDTH-1:0] acc_in,
   input  logic [NE*5-1:0]         exp_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [15:0]             out_data,
   output logic [IDX_W-1:0]        out_idx,
   output logic                    out_last,
   output logic                    busy,
   output logic                    overrun
);

   localparam int CW = $clog2(NE + 1);

   drain_state_e                  state_d, state_q;
   logic [CW-1:0]                 cnt_d, cnt_q;
   logic                          acc_done_d, acc_done_q;
   logic [NE-1:0][ACC_WIDTH-1:0]  bank_acc_d, bank_acc_q;
   logic [NE-1:0][4:0]            bank_exp_d, bank_exp_q;
   logic                          out_valid_d, out_valid_q;
   logic [15:0]                   out_data_d, out_data_q;
   logic [IDX_W-1:0]              out_idx_d, out_idx_q;
   logic                          out_last_d, out_last_q;
   logic                          overrun_d, overrun_q;

   logic                          cap;
   logic                          hs;
   logic [IDX_W-1:0]              sel_idx;
   logic [15:0]                   conv_fp16;

   assign cap     = acc_done & ~acc_done_q;
   assign hs      = out_valid_q & out_ready;
   assign sel_idx = (cnt_q < CW'(NE)) ? cnt_q[IDX_W-1:0] : '0;

   fx_to_fp16 #(
      .ACC_WIDTH (ACC_WIDTH),
      .FRAC_BITS (FRAC_BITS)
   ) u_conv (
      .acc  (bank_acc_q[sel_idx]),
      .exp  (bank_exp_q[sel_idx]),
      .fp16 (conv_fp16)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_done_d  = acc_done;
      bank_acc_d  = bank_acc_q;
      bank_exp_d  = bank_exp_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      overrun_d   = overrun_q;

      case (state_q)
         IDLE: begin
            if (cap) begin
               bank_acc_d = acc_in;
               bank_exp_d = exp_in;
               cnt_d      = '0;
               state_d    = LOAD;
            end
         end
         LOAD: begin
            out_data_d  = conv_fp16;
            out_idx_d   = '0;
            out_valid_d = 1'b1;
            out_last_d  = (NE == 1);
            cnt_d       = CW'(1);
            state_d     = DRAIN;
         end
         DRAIN: begin
            if (hs) begin
               if (out_last_q) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  state_d     = IDLE;
               end else if (cnt_q < CW'(NE)) begin
                  out_data_d = conv_fp16;
                  out_idx_d  = sel_idx;
                  out_last_d = (cnt_q == CW'(NE - 1));
                  cnt_d      = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A tile arriving before the current one has fully drained is dropped.
      if (cap && (state_q != IDLE)) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_done_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_done_q  <= acc_done_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         overrun_q   <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      bank_acc_q <= bank_acc_d;
      bank_exp_q <= bank_exp_d;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != IDLE);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: queue-based reference of tiles, captures, overrun and drain timing.
module tb_systolic_drain;

   localparam int AW = 32;
   localparam int N  = 2;
   localparam int NE = N * N;
   localparam int FB = 10;

   logic              clk = 1'b0;
   logic              rst;
   logic              acc_done;
   logic [NE*AW-1:0]  acc_in;
   logic [NE*5-1:0]   exp_in;
   logic              out_valid;
   logic              out_ready;
   logic [15:0]       out_data;
   logic [1:0]        out_idx;
   logic              out_last;
   logic              busy;
   logic              overrun;

   systolic_drain #(.ACC_WIDTH(AW), .N(N), .FRAC_BITS(FB)) dut (
      .clk       (clk),
      .rst       (rst),
      .acc_done  (acc_done),
      .acc_in    (acc_in),
      .exp_in    (exp_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      int          idx;
      logic        last;
   } exp_t;

   exp_t        mq[$];
   logic [17:0] log_q[$];
   exp_t        tmp_e;
   int          checks = 0, passes = 0, fails = 0;
   int          age = 0, hs_count = 0, rmode = 0, phase = 0;
   logic        ov_exp = 1'b0, done_prev = 1'b0, chk_en = 1'b0;
   logic signed [31:0] tile_a [NE];
   logic [4:0]         tile_e [NE];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end else begin
         passes++;
      end
   endtask

   // value = acc * 2^(exp-15-FB); encode the magnitude as 1.f * 2^(E-15) by arithmetic.
   function automatic logic [15:0] ref_fp16(input logic signed [31:0] a, input logic [4:0] e);
      longint m, v;
      int     p, ex, mant;
      logic   sgn;
      sgn = a[31];
      m   = sgn ? -longint'(a) : longint'(a);
      if (m == 0) return 16'h0000;
      p = 0;
      v = m;
      while (v > 1) begin
         v = v / 2;
         p++;
      end
      ex = int'(e) + p - FB;
      if (ex >= 31) return {sgn, 15'h7C00};
      if (ex <= 0)  return {sgn, 15'h0000};
      mant = int'((m * 1024) / (longint'(1) << p)) - 1024;
      return {sgn, ex[4:0], mant[9:0]};
   endfunction

   function automatic logic signed [31:0] rand_acc();
      logic signed [31:0] r;
      case ($urandom_range(0, 4))
         0: r = 0;
         1: r = $urandom_range(1, 4095);
         2: r = $urandom;
         3: r = 32'sh8000_0000;
         default: r = -$signed({20'h0, 12'($urandom_range(1, 4095))});
      endcase
      return r;
   endfunction

   task automatic apply_tile();
      for (int i = 0; i < NE; i++) begin
         acc_in[i*AW +: AW] = tile_a[i];
         exp_in[i*5 +: 5]   = tile_e[i];
      end
   endtask

   task automatic rand_tile();
      for (int i = 0; i < NE; i++) begin
         tile_a[i] = rand_acc();
         tile_e[i] = 5'($urandom_range(0, 31));
      end
      apply_tile();
   endtask

   task automatic pulse_done();
      @(posedge clk); #1 acc_done = 1'b1;
      @(posedge clk); #1 acc_done = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while ((mq.size() != 0 || busy) && n < lim) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain_timeout", 32'(n < lim), 32'd1);
   endtask

   // Ready pattern generator: 0 always, 1 = 1,0,0 repeating, 2 random, 3 never.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rmode)
            0: out_ready = 1'b1;
            1: begin out_ready = (phase % 3 == 0); phase++; end
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Reference model and per-cycle compare.
   always @(negedge clk) begin
      logic hs, cap, occupied;
      if (chk_en) begin
         if (mq.size() > 0) age++;
         check("out_valid", 32'(out_valid), 32'((mq.size() > 0) && (age >= 2)));
         check("busy", 32'(busy), 32'((mq.size() > 0) && (age >= 1)));
         check("overrun", 32'(overrun), 32'(ov_exp));
         if (out_valid && mq.size() > 0) begin
            check("out_data", 32'(out_data), 32'(mq[0].data));
            check("out_idx", 32'(out_idx), 32'(mq[0].idx));
            check("out_last", 32'(out_last), 32'(mq[0].last));
         end
         hs       = out_valid && out_ready;
         cap      = acc_done && !done_prev;
         occupied = (mq.size() > 0);
         if (rst) begin
            mq.delete();
            ov_exp    = 1'b0;
            done_prev = 1'b0;
            age       = 0;
         end else begin
            if (hs && occupied) begin
               log_q.push_back({out_idx, out_data});
               void'(mq.pop_front());
               hs_count++;
            end
            if (cap) begin
               if (occupied) begin
                  ov_exp = 1'b1;
               end else begin
                  for (int i = 0; i < NE; i++) begin
                     tmp_e.data = ref_fp16(acc_in[i*AW +: AW], exp_in[i*5 +: 5]);
                     tmp_e.idx  = i;
                     tmp_e.last = (i == NE - 1);
                     mq.push_back(tmp_e);
                  end
                  age = 0;
               end
            end
            done_prev = acc_done;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int start;
      int n;
      logic [15:0] lit [NE];
      rst      = 1'b1;
      acc_done = 1'b0;
      acc_in   = '0;
      exp_in   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_idx", 32'(out_idx), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      chk_en = 1'b1;

      // Model anchors from hand-worked encodings.
      check("pin_1024_e15", 32'(ref_fp16(32'sd1024, 5'd15)), 32'h3C00);
      check("pin_m3072_e15", 32'(ref_fp16(-32'sd3072, 5'd15)), 32'hC200);
      check("pin_2049_e15", 32'(ref_fp16(32'sd2049, 5'd15)), 32'h4000);
      check("pin_min_e0", 32'(ref_fp16(32'sh8000_0000, 5'd0)), 32'hD400);

      // Directed tile.
      rmode = 0;
      tile_a = '{32'sd1024, -32'sd3072, 32'sd0, 32'sd2049};
      tile_e = '{5'd15, 5'd15, 5'd15, 5'd15};
      apply_tile();
      log_q.delete();
      pulse_done();
      wait_idle(50);
      lit = '{16'h3C00, 16'hC200, 16'h0000, 16'h4000};
      check("dir_count", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < NE && i < log_q.size(); i++) begin
         check("dir_data", 32'(log_q[i][15:0]), 32'(lit[i]));
         check("dir_idx", 32'(log_q[i][17:16]), 32'(i));
      end

      // Saturation, flush and most-negative corner.
      tile_a = '{32'sd1024, -32'sd1024, 32'sd1, 32'sh8000_0000};
      tile_e = '{5'd31, 5'd31, 5'd5, 5'd0};
      apply_tile();
      log_q.delete();
      pulse_done();
      wait_idle(50);
      lit = '{16'h7C00, 16'hFC00, 16'h0000, 16'hD400};
      check("sat_count", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < NE && i < log_q.size(); i++)
         check("sat_data", 32'(log_q[i][15:0]), 32'(lit[i]));

      // Backpressure 1,0,0 pattern.
      rmode = 1;
      rand_tile();
      log_q.delete();
      pulse_done();
      wait_idle(100);
      check("bp_count", 32'(log_q.size()), 32'd4);
      for (int i = 0; i < NE && i < log_q.size(); i++)
         check("bp_idx", 32'(log_q[i][17:16]), 32'(i));

      // Held-high done captures exactly once.
      rmode = 0;
      rand_tile();
      start = hs_count;
      @(posedge clk); #1 acc_done = 1'b1;
      repeat (20) @(posedge clk);
      #1 acc_done = 1'b0;
      wait_idle(50);
      check("held_hs", 32'(hs_count - start), 32'd4);
      check("held_overrun", 32'(overrun), 32'd0);

      // Second edge mid-drain is dropped and flagged.
      rmode = 1;
      rand_tile();
      pulse_done();
      repeat (4) @(posedge clk);
      rand_tile();
      pulse_done();
      wait_idle(100);
      check("ovr_sticky", 32'(overrun), 32'd1);

      // Reset after two handshakes.
      rmode = 0;
      rand_tile();
      start = hs_count;
      pulse_done();
      n = 0;
      while (hs_count < start + 2 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      check("mid_hs_timeout", 32'(n < 50), 32'd1);
      @(posedge clk); #1;
      rst   = 1'b1;
      rmode = 3;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("mid_valid", 32'(out_valid), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_overrun", 32'(overrun), 32'd0);
      rmode = 0;
      rand_tile();
      log_q.delete();
      pulse_done();
      wait_idle(50);
      check("restart_count", 32'(log_q.size()), 32'd4);
      if (log_q.size() > 0)
         check("restart_idx0", 32'(log_q[0][17:16]), 32'd0);

      // Randomized tiles, ready and capture spacing.
      rmode = 2;
      repeat (40) begin
         rand_tile();
         pulse_done();
         repeat ($urandom_range(0, 12)) @(posedge clk);
      end
      wait_idle(200);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Downstream stage of the N×N FP-INT systolic array.
- On each completion of the array's `done` it snapshots all N*N accumulator/exponent pairs into a local bank.
- It converts each pair from block fixed-point to IEEE FP16 and streams the results out one per cycle over a valid/ready interface, in row-major PE order.
- This frees the array to start the next tile while results drain.

Parameters:
- ACC_WIDTH, 32, width of each signed two's-complement PE accumulator.
- N, 2, array dimension; N*N elements per tile.
- FRAC_BITS, 10, number of fraction bits in the fixed-point accumulator.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- acc_done  in  1  array `done` level; a rising edge triggers capture.
- acc_in  in  ACC_WIDTH × [N*N-1:0]  PE fixed-point accumulators; index i*N+j.
- exp_in  in  5 × [N*N-1:0]  PE exponents; same indexing.
- out_valid  out  1  out_data/out_idx valid.
- out_ready  in  1  consumer accepts.
- out_data  out  16  FP16 result.
- out_idx  out  IDX_W = max(1,$clog2(N*N))  PE index of out_data.
- out_last  out  1  asserted with element N*N-1.
- busy  out  1  high while not IDLE.
- overrun  out  1  sticky; a capture edge was lost.

Behaviour:
- Reset (rst=1 at posedge) drives these to 0:
  - out_valid, out_data, out_idx, out_last, busy, overrun;
  - state=IDLE, element counter, acc_done_q.
- Reset mid-drain discards the bank with no further output.
- Edge detect:
  - acc_done_q <= acc_done every cycle.
  - cap = acc_done & ~acc_done_q.
  - A held-high done captures once.
- States are IDLE, LOAD, DRAIN.
- IDLE:
  - On cap, latch all acc_in/exp_in into the bank, set cnt=0, go to LOAD.
- LOAD:
  - out_data <= convert(bank[0]), out_idx <= 0, out_valid <= 1, out_last <= (N*N==1), cnt <= 1.
  - Go to DRAIN.
  - First out_valid is seen 2 cycles after the capture edge.
- DRAIN:
  - A handshake is out_valid & out_ready.
  - On a handshake with cnt < N*N, load bank[cnt] into the output register and increment cnt. This gives one result per cycle under continuous ready.
  - On a handshake of the out_last element, clear out_valid and out_last and go to IDLE.
  - Without a handshake, out_data, out_idx and out_last hold stable.
- Overrun:
  - A cap in LOAD or DRAIN is ignored and sets overrun=1.
  - overrun clears only on rst.
  - A cap in the same cycle as the final handshake is also an overrun; the new tile is not captured.
- Conversion, as a value formula:
  - value = acc × 2^(exp − 15 − FRAC_BITS), with acc signed.
- Conversion, as steps:
  - sign = acc[MSB].
  - mag = |acc| as an unsigned ACC_WIDTH-bit value, so −2^(ACC_WIDTH−1) yields 2^(ACC_WIDTH−1) correctly.
  - mag==0 → 0x0000.
  - p = index of the leading one; E = exp + p − FRAC_BITS, computed signed and wide enough for no overflow.
  - E ≥ 31 → {sign, 0x7C00} (±Inf, saturate).
  - E ≤ 0 → {sign, 15'h0} (flush to signed zero, no subnormals).
  - Otherwise mantissa = the 10 bits directly below p, truncated (round toward zero); bits below bit 0 are zero-filled when p < 10.
  - Result = {sign, E[4:0], mantissa}.
- Conversion is combinational from the bank into the output register; there is no extra pipeline stage.

Decomposition:
- Package `fp16_pkg` holds:
  - FP16_EXP_BIAS=15, FP16_EXP_MAX=31, FP16_MANT_W=10;
  - FP16_INF=16'h7C00;
  - the state enum {IDLE, LOAD, DRAIN}.
- Sub-module `fx_to_fp16`:
  - combinational; inputs acc[ACC_WIDTH], exp[5]; output fp16[16];
  - contains the LZC and pack logic.
- The converter is tested standalone with the same vectors as the array-level bench.

Test Plan:
- N=2, acc={1024, −3072, 0, 2049}, exp all 15, pulse acc_done, out_ready=1 → data 0x3C00, 0xC200, 0x0000, 0x4000 on consecutive cycles; idx 0..3; out_last only with idx 3; first valid 2 cycles after the capture edge.
- acc=1024, exp=31 → 0x7C00; acc=−1024, exp=31 → 0xFC00; acc=1, exp=5 → 0x0000; acc=−2^31, exp=0 → E=21 → 0xD400.
- Backpressure: toggle out_ready 1,0,0,1,… → each element is held stable while ready=0; all 4 delivered exactly once, in order.
- acc_done held high for 20 cycles → exactly one tile of 4 outputs; overrun stays 0.
- Second acc_done rising edge during DRAIN → ignored, overrun=1 until rst; the current tile completes unchanged.
- rst asserted after 2 of 4 handshakes → next cycle out_valid=0, busy=0, overrun=0; a new capture restarts at idx 0.
